// File: rtl/bitserial_logic4_unit.sv
// Bit-serial 4-function logic unit: evaluates AND/OR/XOR/NOR one bit per cycle, LSB first.
// Optional macro BSL_ZERO_FLAG_EN adds a registered zero-result flag output.
module bitserial_logic4_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
`ifdef BSL_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             bit_now;
  logic             last_bit;

  function automatic logic gate(input logic [1:0] o, input logic a, input logic b);
    case (o)
      2'b00:   gate = a & b;
      2'b01:   gate = a | b;
      2'b10:   gate = a ^ b;
      default: gate = ~(a | b);
    endcase
  endfunction

  assign bit_now  = gate(op_q, a_sh[0], b_sh[0]);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res      = acc;

`ifdef BSL_ZERO_FLAG_EN
  logic seen_one;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      op_q      <= '0;
`ifdef BSL_ZERO_FLAG_EN
      seen_one  <= 1'b0;
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sh      <= A;
            b_sh      <= B;
            op_q      <= op;
            acc       <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SHIFT;
`ifdef BSL_ZERO_FLAG_EN
            seen_one  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          // New bit enters at the MSB so bit 0 lands at acc[0] after WIDTH shifts.
          acc  <= {bit_now, acc[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
`ifdef BSL_ZERO_FLAG_EN
          seen_one <= seen_one | bit_now;
`endif
          if (last_bit) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
`ifdef BSL_ZERO_FLAG_EN
            zero      <= ~(seen_one | bit_now);
`endif
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
`ifdef BSL_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_logic4_unit.sv
// Self-checking bench for bitserial_logic4_unit against a word-level bitwise reference model.
module tb_bitserial_logic4_unit;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] res;
  logic         busy;
  logic         zero;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bitserial_logic4_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .res       (res),
    .busy      (busy)
`ifdef BSL_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

`ifndef BSL_ZERO_FLAG_EN
  assign zero = 1'b0;
`endif

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      2'b00:   model = a & b;
      2'b01:   model = a | b;
      2'b10:   model = a ^ b;
      default: model = ~(a | b);
    endcase
  endfunction

  // Drives one transaction; returns the observed result and flags for the caller to judge.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, output logic [W-1:0] r, output logic z,
                        output int lat, output bit hold_ok, output bit post_idle,
                        output bit timeout);
    int n;
    hold_ok = 1'b1;
    timeout = 1'b0;
    @(negedge clock);
    op = o; A = a; B = b; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) timeout = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); op = 2'($urandom);
    @(negedge clock);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (!busy || req_ready || zero) hold_ok = 1'b0;
      A = W'($urandom); op = 2'($urandom);
      @(negedge clock);
      lat++;
    end
    if (lat >= 50) timeout = 1'b1;
    r = res;
    z = zero;
    for (int i = 0; i < stall; i++) begin
      if (!rsp_valid || res !== r || zero !== z || !busy || req_ready) hold_ok = 1'b0;
      req_valid = 1'($urandom);
      A = W'($urandom); B = W'($urandom); op = 2'($urandom);
      @(negedge clock);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    post_idle = !rsp_valid && req_ready && !busy && !zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || res !== '0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: req_ready=%b rsp_valid=%b busy=%b res=%h zero=%b required 1 0 0 0 0",
               req_ready, rsp_valid, busy, res, zero);
    end
  endtask

  task automatic test_or_latency();
    logic [W-1:0] r; logic z; int lat; bit h, p, t;
    run_op(2'b01, 4'b1010, 4'b0101, 0, r, z, lat, h, p, t);
    checks++;
    if (r !== 4'b1111) begin errors++; $display("FAIL or_res: got %b required 1111", r); end
    checks++;
    if (t || lat + 1 !== 5) begin errors++; $display("FAIL or_latency: rsp_valid in cycle %0d after accept, required 5", lat + 1); end
    checks++;
    if (!h) begin errors++; $display("FAIL or_busy_hold: busy/req_ready wrong during op, required busy=1 req_ready=0"); end
    checks++;
    if (!p) begin errors++; $display("FAIL or_return_idle: rsp_valid=%b req_ready=%b busy=%b required 0 1 0", rsp_valid, req_ready, busy); end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] want [4];
    logic [W-1:0] r; logic z; int lat; bit h, p, t;
    want[0] = 4'b1000; want[1] = 4'b1110; want[2] = 4'b0110; want[3] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      run_op(2'(k), 4'b1100, 4'b1010, 0, r, z, lat, h, p, t);
      checks++;
      if (t || r !== want[k]) begin errors++; $display("FAIL all_ops op=%0d: got %b required %b", k, r, want[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; logic z; int lat; bit h, p, t;
    run_op(2'b10, 4'b1001, 4'b0011, 10, r, z, lat, h, p, t);
    checks++;
    if (t || r !== 4'b1010) begin errors++; $display("FAIL bp_res: got %b required 1010", r); end
    checks++;
    if (!h) begin errors++; $display("FAIL bp_hold: outputs moved or request accepted while stalled, required stable"); end
    checks++;
    if (!p) begin errors++; $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second: busy=%b rsp_valid=%b required 0 0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r; logic z; int lat; bit h, p, t; bit spurious;
    @(negedge clock);
    op = 2'b00; A = 4'hF; B = 4'hF; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || res !== '0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rsp_valid=%b res=%h req_ready=%b busy=%b required 0 0 1 0", rsp_valid, res, req_ready, busy);
    end
    spurious = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid || busy) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin errors++; $display("FAIL mid_reset_partial: response or busy seen after abort, required none"); end
    run_op(2'b10, 4'hF, 4'h3, 0, r, z, lat, h, p, t);
    checks++;
    if (t || r !== 4'hC) begin errors++; $display("FAIL mid_reset_fresh: got %h required c", r); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got [$];
    int accepts;
    bit acc_now, rsp_now;
    accepts = 0;
    @(negedge clock);
    op = 2'b00; A = 4'h6; B = 4'h3; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc_now = req_valid && req_ready;
      rsp_now = rsp_valid && rsp_ready;
      if (rsp_now) got.push_back(res);
      @(posedge clock);
      #1;
      if (acc_now) begin
        accepts++;
        if (accepts == 1) op = 2'b01;
        else req_valid = 1'b0;
      end
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (got.size() !== 2 || accepts !== 2) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d accepts=%0d required 2 2", got.size(), accepts);
    end else begin
      checks++;
      if (got[0] !== 4'h2 || got[1] !== 4'h7) begin
        errors++;
        $display("FAIL b2b_order: got %h,%h required 2,7", got[0], got[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r; logic [1:0] o; logic z; int lat; bit h, p, t;
    for (int k = 0; k < 40; k++) begin
      a = W'($urandom); b = W'($urandom); o = 2'($urandom);
      run_op(o, a, b, int'($urandom_range(0, 3)), r, z, lat, h, p, t);
      checks++;
      if (t || r !== model(o, a, b)) begin
        errors++;
        $display("FAIL rand_res op=%0d a=%h b=%h: got %h required %h", o, a, b, r, model(o, a, b));
      end
      checks++;
      if (lat !== W || !h || !p) begin
        errors++;
        $display("FAIL rand_protocol: lat=%0d hold=%0d idle=%0d required %0d 1 1", lat, h, p, W);
      end
`ifdef BSL_ZERO_FLAG_EN
      checks++;
      if (z !== (model(o, a, b) == '0)) begin
        errors++;
        $display("FAIL rand_zero: got %b required %b", z, (model(o, a, b) == '0));
      end
`endif
    end
  endtask

`ifdef BSL_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic [W-1:0] r; logic z; int lat; bit h, p, t;
    run_op(2'b00, 4'b0101, 4'b1010, 0, r, z, lat, h, p, t);
    checks++;
    if (r !== 4'h0 || z !== 1'b1) begin errors++; $display("FAIL zero_and: res=%h zero=%b required 0 1", r, z); end
    run_op(2'b01, 4'b0101, 4'b1010, 0, r, z, lat, h, p, t);
    checks++;
    if (r !== 4'hF || z !== 1'b0) begin errors++; $display("FAIL zero_or: res=%h zero=%b required f 0", r, z); end
    checks++;
    if (!h || !p) begin errors++; $display("FAIL zero_outside_valid: zero nonzero while rsp_valid=0"); end
  endtask
`endif

  initial begin
    test_reset();
    test_or_latency();
    test_all_ops();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
`ifdef BSL_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
